// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipelined ARM core (F, D, E, M, W).
// Generates F/D/E stall and flush enables and the E-stage operand forwarding
// selects. In-flight PC writes are tracked in a three-stage shadow register.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_W  = 4,
   parameter int unsigned PC_REG = 15,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] RA1D,
   input  logic [REG_W-1:0] RA2D,
   input  logic [REG_W-1:0] RA1E,
   input  logic [REG_W-1:0] RA2E,
   input  logic [REG_W-1:0] WA3E,
   input  logic [REG_W-1:0] WA3M,
   input  logic [REG_W-1:0] WA3W,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             PCSrcD,
   input  logic             BranchTakenE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       HazState
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
`endif
);

   localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LD_STALL = 2'b01,
      PC_WAIT  = 2'b10,
      BR_FLUSH = 2'b11
   } haz_state_t;

   haz_state_t state_q;
   haz_state_t state_d;
   logic [2:0] pend;       // PC write in flight: [0]=E, [1]=M, [2]=W
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       ldr_stall;
   logic       pc_wr_pending;
   logic       stall_f;
   logic       flush_d;
   logic       flush_e;

   // Forwarding selects, load-use detection and raw stall/flush equations
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (RegWriteM && (RA1E == WA3M) && (RA1E != PC_IDX))      fwd_a = 2'b10;
      else if (RegWriteW && (RA1E == WA3W) && (RA1E != PC_IDX)) fwd_a = 2'b01;
      if (RegWriteM && (RA2E == WA3M) && (RA2E != PC_IDX))      fwd_b = 2'b10;
      else if (RegWriteW && (RA2E == WA3W) && (RA2E != PC_IDX)) fwd_b = 2'b01;

      ldr_stall = MemtoRegE && RegWriteE &&
                  (((RA1D == WA3E) && (RA1D != PC_IDX)) ||
                   ((RA2D == WA3E) && (RA2D != PC_IDX)));
      pc_wr_pending = PCSrcD || pend[0] || pend[1];
      stall_f       = ldr_stall || pc_wr_pending;
      // Branch flush of D wins over the load-use hold of the F/D register
      flush_d       = pc_wr_pending || pend[2] || BranchTakenE;
      flush_e       = ldr_stall || BranchTakenE;
   end

   // Reset forces a safe bubble-everything output pattern
   always_comb begin
      ForwardAE = reset ? fwd_a : 2'b00;
      ForwardBE = reset ? fwd_b : 2'b00;
      StallF    = reset && stall_f;
      StallD    = reset && ldr_stall;
      FlushD    = !reset || flush_d;
      FlushE    = !reset || flush_e;
      HazState  = state_q;
   end

   // PC-write shadow: advance one stage per edge, drop the E entry on a taken branch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= 3'b000;
      end else begin
         pend <= {pend[1], pend[0] && !BranchTakenE, PCSrcD && !flush_e};
      end
   end

   // Hazard state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Hazard state next-state priority
   always_comb begin
      state_d = RUN;
      if (BranchTakenE)                  state_d = BR_FLUSH;
      else if (ldr_stall)                state_d = LD_STALL;
      else if (pc_wr_pending || pend[2]) state_d = PC_WAIT;
   end

`ifdef HAZ_PERF_CNT_EN
   // Saturating performance counters for fetch stalls and taken-branch flushes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (stall_f && (StallCnt != '1))      StallCnt <= StallCnt + CNT_W'(1);
         if (BranchTakenE && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard controller for the 5-stage pipelined ARM core (F, D, E, M, W).
- Sequences the pipeline registers and the conditional-execution datapath by generating:
  - stall and flush enables for F, D and E;
  - forwarding selects for the E-stage ALU operands.
- Tracks in-flight PC writes internally with a stage shadow register, so fetch stays stalled until the new PC is written back.
- Exposes a registered hazard state for debug and the performance counter.

Parameters:
- REG_W, 4, register-address width.
- PC_REG, 15, register index of the PC; never forwarded, never causes a load-use stall.
- CNT_W, 16, stall-counter width (optional feature only).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous reset, active low.
- RA1D, RA2D  in  REG_W  source registers of the instruction in D.
- RA1E, RA2E  in  REG_W  source registers of the instruction in E.
- WA3E, WA3M, WA3W  in  REG_W  destination registers in E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage (already condition-qualified in M and W).
- MemtoRegE  in  1  the instruction in E is a load.
- PCSrcD  in  1  the instruction in D writes the PC.
- BranchTakenE  in  1  branch resolved taken in E (BranchE & CondEx).
- ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD  out  1  hold the PC register and the F/D register.
- FlushD, FlushE  out  1  load a bubble into the F/D and D/E registers.
- HazState  out  2  registered state: 00 RUN, 01 LD_STALL, 10 PC_WAIT, 11 BR_FLUSH.

Behaviour:
- Forwarding, combinational, per operand X in {1,2}:
  - 10 if RAXE==WA3M & RegWriteM & RAXE!=PC_REG;
  - else 01 if RAXE==WA3W & RegWriteW & RAXE!=PC_REG;
  - else 00.
  - M has priority over W.
- Load-use: LDRstall = MemtoRegE & RegWriteE & ((RA1D==WA3E & RA1D!=PC_REG) | (RA2D==WA3E & RA2D!=PC_REG)).
- Pending PC-write shadow pend[2:0] (pend[0] = E, pend[1] = M, pend[2] = W). On each rising edge:
  - pend[0] <= PCSrcD & ~FlushE;
  - pend[1] <= pend[0] & ~BranchTakenE;
  - pend[2] <= pend[1].
  - A PC write squashed by a taken branch (pend[0] & BranchTakenE) is dropped.
- PCWrPending = PCSrcD | pend[0] | pend[1].
- Outputs:
  - StallF = LDRstall | PCWrPending.
  - StallD = LDRstall.
  - FlushD = PCWrPending | pend[2] | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
- Simultaneous events:
  - BranchTakenE & LDRstall: FlushE=1 and StallD=1; D is also flushed (FlushD=1), and the flush takes precedence over the stall on the F/D register.
  - BranchTakenE & PCWrPending: both flushes are asserted; pend is updated as above.
- HazState next-state priority, registered:
  - BranchTakenE -> BR_FLUSH;
  - else LDRstall -> LD_STALL;
  - else PCWrPending | pend[2] -> PC_WAIT;
  - else RUN.
  - LD_STALL lasts exactly 1 cycle per load-use hazard.
  - PC_WAIT lasts 4 cycles for an unsquashed PC write (D, E, M, W).
- Reset (reset=0, asynchronous):
  - pend=000, HazState=00.
  - Outputs forced: StallF=StallD=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00.
- On reset release, outputs follow the equations from the next evaluation. A reset mid-stall discards all pending state; no PC write is tracked after release.
- Latency: forwarding, stall and flush outputs are combinational in the same cycle; pend and HazState take effect one cycle after the edge.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCnt (CNT_W) and FlushCnt (CNT_W).
  - StallCnt increments on each edge where StallF=1.
  - FlushCnt increments on each edge where BranchTakenE=1.
  - Both counters saturate at all-ones and clear to 0 on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then RA1E=15 -> ForwardAE=00.
- Load in E (MemtoRegE=1, RegWriteE=1, WA3E=5), RA2D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle, HazState=01 the next cycle. Repeat with WA3E=15 -> no stall.
- PCSrcD=1 for one cycle, no branch -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles, HazState=10 for 4 cycles, then RUN.
- BranchTakenE=1 while pend[0]=1 -> FlushD=FlushE=1, HazState=11. The pending PC write is dropped: StallF deasserts the next cycle if PCSrcD=0.
- Assert reset=0 mid PC_WAIT -> asynchronously FlushD=FlushE=1, StallF=0, HazState=00. After release with all inputs 0 -> all outputs 0.
- With HAZ_PERF_CNT_EN defined: 3 load-use stalls plus 2 taken branches -> StallCnt=3, FlushCnt=2. Preload near all-ones, then continue stalling -> StallCnt holds at all-ones.
